regfile_sb: RTL

- Parametrised multi-port integer register file with a write-back scoreboard. Successor to the single-write-port register file that currently lives inside the decode stage.
- Sits in the ID stage: serves operand reads for the instruction in decode and accepts NWR write-back ports.
- Tracks registers with an in-flight producer; stalls issue on RAW/WAW hazards that forwarding cannot resolve.
- x0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 68 ++++++
 rtl/regfile_sb.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its write-back scoreboard.
// Address width helper plus default-configuration typedefs.
package regfile_pkg;

  function automatic int addr_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = addr_w(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an in-flight producer and
// decides whether the instruction in decode may issue this cycle.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREGS-1:0]  clr,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD-1:0]    rd_used,
  input  logic              issue_valid,
  input  logic              issue_wb,
  input  logic [AW-1:0]     issue_rd,
  input  logic              flush,
  output logic              issue_ready,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_eff;
  logic [NREGS-1:0] set;
  logic             hazard;
  logic             fire;

  // A register being written back this cycle is not a hazard: the bypass
  // in the register file already supplies its value.
  always_comb begin
    busy_eff = busy & ~clr;
    hazard   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_used[i] && busy_eff[rd_addr[i*AW +: AW]]) begin
        hazard = 1'b1;
      end
    end
    if (issue_wb && busy_eff[issue_rd]) begin
      hazard = 1'b1;
    end
  end

  assign issue_ready = ~flush & ~hazard;
  assign fire        = issue_valid & issue_ready;

  always_comb begin
    set = '0;
    if (fire && issue_wb) begin
      set[issue_rd] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      set[0] = 1'b0;
    end
  end

  // A new producer outranks a write-back clearing the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= set | (busy & ~clr);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-first bypass; hazard tracking
// is delegated to rf_scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_used,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_valid,
  input  logic                issue_wb,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                flush,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [XLEN-1:0]  wdat [NREGS];
  logic [NREGS-1:0] clr;
  logic [AW-1:0]    rd_sel [NRD];

  // Per-register write resolution; later ports overwrite earlier ones so the
  // highest-indexed port wins on a collision.
  always_comb begin
    clr = '0;
    for (int r = 0; r < NREGS; r++) begin
      wdat[r] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        clr[wr_addr[j*AW +: AW]]  = 1'b1;
        wdat[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (clr[r] && !((ZERO_REG != 0) && (r == 0))) begin
          regs[r] <= wdat[r];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd_sel
    assign rd_sel[i] = rd_addr[i*AW +: AW];
  end

  // Write-first read: a same-cycle write-back is visible before it is stored.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((ZERO_REG != 0) && (rd_sel[i] == '0)) begin
        rd_data[i*XLEN +: XLEN] = '0;
      end else if (clr[rd_sel[i]]) begin
        rd_data[i*XLEN +: XLEN] = wdat[rd_sel[i]];
      end else begin
        rd_data[i*XLEN +: XLEN] = regs[rd_sel[i]];
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .rd_addr     (rd_addr),
    .rd_used     (rd_used),
    .issue_valid (issue_valid),
    .issue_wb    (issue_wb),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .issue_ready (issue_ready),
    .busy        (busy)
  );

endmodule
